// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore sequencer for the multicycle MIPS datapath.
// Control outputs are decoded from the current state and are all held at 0 while reset is low.
module mips_multicycle_controller #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state_o
);
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J = 6'b000010;

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
        MEMWB = 4'd4, MEMWR = 4'd5, RTYPEEX = 4'd6, RTYPEWB = 4'd7,
        BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11
    } state_t;

    state_t state;
    logic ready;
    logic pcwrite;
    logic branch;
    logic aluen;
    logic [1:0] aluop;
    logic [2:0] funct_ctl;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   state <= ready ? DECODE : FETCH;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= RTYPEEX;
                        OP_BEQ:       state <= BEQEX;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JEX;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   state <= ready ? MEMWB : MEMRD;
                MEMWR:   state <= ready ? FETCH : MEMWR;
                RTYPEEX: state <= RTYPEWB;
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        irwrite = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        iord = 1'b0;
        memtoreg = 1'b0;
        regdst = 1'b0;
        alusrca = 1'b0;
        alusrcb = 2'b00;
        pcsrc = 2'b00;
        illegal_op = 1'b0;
        pcwrite = 1'b0;
        branch = 1'b0;
        aluen = 1'b0;
        aluop = 2'b00;
        if (reset) begin
            case (state)
                FETCH: begin
                    alusrcb = 2'b01;
                    aluen = 1'b1;
                    irwrite = ready;
                    pcwrite = ready;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    aluen = 1'b1;
                    illegal_op = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
                end
                MEMADR, ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluen = 1'b1;
                end
                MEMRD: iord = 1'b1;
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    iord = 1'b1;
                    memwrite = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluen = 1'b1;
                    aluop = 2'b10;
                end
                RTYPEWB: begin
                    regdst = 1'b1;
                    regwrite = 1'b1;
                end
                BEQEX: begin
                    alusrca = 1'b1;
                    aluen = 1'b1;
                    aluop = 2'b01;
                    pcsrc = 2'b01;
                    branch = 1'b1;
                end
                ADDIWB: regwrite = 1'b1;
                JEX: begin
                    pcsrc = 2'b10;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Unlisted functs fall back to add so a bad R-type still produces a defined result.
    assign funct_ctl = (funct == 6'b100010) ? 3'b110 :
                       (funct == 6'b100100) ? 3'b000 :
                       (funct == 6'b100101) ? 3'b001 :
                       (funct == 6'b101010) ? 3'b111 : 3'b010;

    assign alucontrol = !aluen ? 3'b000 :
                        (aluop == 2'b00) ? 3'b010 :
                        (aluop == 2'b01) ? 3'b110 : funct_ctl;

    assign pcen = pcwrite | (branch & zero);
    assign state_o = state;
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed and randomized checks of the multicycle controller
// against an instruction-sequence model held in a queue of pending steps.
module tb_mips_multicycle_controller;
    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04, ADDI = 6'h08, JMP = 6'h02, BAD = 6'h3f;
    localparam logic [5:0] F_SUB = 6'b100010;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic zero = 1'b0;
    logic mem_ready = 1'b1;
    logic pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_o;

    int compared = 0;
    int mismatched = 0;
    int q[$];

    mips_multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int cur();
        return (q.size() > 0) ? q[0] : 0;
    endfunction

    function automatic logic [2:0] alu_code(input int kind, input logic [5:0] f);
        if (kind == 1) return 3'b010;
        if (kind == 2) return 3'b110;
        if (kind == 3) begin
            case (f)
                6'b100010: return 3'b110;
                6'b100100: return 3'b000;
                6'b100101: return 3'b001;
                6'b101010: return 3'b111;
                default:   return 3'b010;
            endcase
        end
        return 3'b000;
    endfunction

    // Output word: {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol,illegal_op,state}
    function automatic logic [19:0] model(input int s, input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
        logic pc, ir, mw, rw, io, mtr, rd, sa, ill;
        logic [1:0] sb, ps;
        int kind;
        {pc, ir, mw, rw, io, mtr, rd, sa, ill} = '0;
        sb = 2'b00;
        ps = 2'b00;
        kind = 0;
        case (s)
            0: begin sb = 2'b01; kind = 1; ir = r; pc = r; end
            1: begin sb = 2'b11; kind = 1; ill = !(o inside {LW, SW, RT, BEQ, ADDI, JMP}); end
            2, 9: begin sa = 1; sb = 2'b10; kind = 1; end
            3: io = 1;
            4: begin mtr = 1; rw = 1; end
            5: begin io = 1; mw = 1; end
            6: begin sa = 1; kind = 3; end
            7: begin rd = 1; rw = 1; end
            8: begin sa = 1; kind = 2; ps = 2'b01; pc = z; end
            10: rw = 1;
            11: begin ps = 2'b10; pc = 1; end
            default: ;
        endcase
        return {pc, ir, mw, rw, io, mtr, rd, sa, sb, ps, alu_code(kind, f), ill, 4'(s)};
    endfunction

    always @(negedge clk) begin
        logic [19:0] got, exp;
        int s;
        got = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state_o};
        s = cur();
        exp = reset ? model(s, op, funct, zero, mem_ready) : 20'd0;
        check("outputs", 32'(got), 32'(exp));
        if (!reset) q.delete();
        else if (s == 0) begin
            if (mem_ready) q.push_back(1);
        end else if (s == 1) begin
            void'(q.pop_front());
            case (op)
                LW:   begin q.push_back(2); q.push_back(3); q.push_back(4); end
                SW:   begin q.push_back(2); q.push_back(5); end
                RT:   begin q.push_back(6); q.push_back(7); end
                BEQ:  q.push_back(8);
                ADDI: begin q.push_back(9); q.push_back(10); end
                JMP:  q.push_back(11);
                default: ;
            endcase
        end else if (!((s == 3 || s == 5) && !mem_ready)) void'(q.pop_front());
    end

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic z;
        logic r;
        int st;
        logic pc;
        logic mw;
        logic rw;
        logic ill;
        logic [2:0] aluc;
    } row_t;

    localparam int NR = 41;
    row_t rows [NR] = '{
        '{LW, 0, 0, 1, 0, 1, 0, 0, 0, 3'b010}, '{LW, 0, 0, 1, 1, 0, 0, 0, 0, 3'b010},
        '{LW, 0, 0, 1, 2, 0, 0, 0, 0, 3'b010}, '{LW, 0, 0, 1, 3, 0, 0, 0, 0, 3'b000},
        '{LW, 0, 0, 1, 4, 0, 0, 1, 0, 3'b000},
        '{SW, 0, 0, 1, 0, 1, 0, 0, 0, 3'b010}, '{SW, 0, 0, 1, 1, 0, 0, 0, 0, 3'b010},
        '{SW, 0, 0, 1, 2, 0, 0, 0, 0, 3'b010}, '{SW, 0, 0, 0, 5, 0, 1, 0, 0, 3'b000},
        '{SW, 0, 0, 0, 5, 0, 1, 0, 0, 3'b000}, '{SW, 0, 0, 1, 5, 0, 1, 0, 0, 3'b000},
        '{RT, F_SUB, 0, 1, 0, 1, 0, 0, 0, 3'b010}, '{RT, F_SUB, 0, 1, 1, 0, 0, 0, 0, 3'b010},
        '{RT, F_SUB, 0, 1, 6, 0, 0, 0, 0, 3'b110}, '{RT, F_SUB, 0, 1, 7, 0, 0, 1, 0, 3'b000},
        '{BEQ, 0, 0, 1, 0, 1, 0, 0, 0, 3'b010}, '{BEQ, 0, 0, 1, 1, 0, 0, 0, 0, 3'b010},
        '{BEQ, 0, 1, 1, 8, 1, 0, 0, 0, 3'b110},
        '{BEQ, 0, 0, 1, 0, 1, 0, 0, 0, 3'b010}, '{BEQ, 0, 0, 1, 1, 0, 0, 0, 0, 3'b010},
        '{BEQ, 0, 0, 1, 8, 0, 0, 0, 0, 3'b110},
        '{BAD, 0, 0, 1, 0, 1, 0, 0, 0, 3'b010}, '{BAD, 0, 0, 1, 1, 0, 0, 0, 1, 3'b010},
        '{ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010}, '{ADDI, 0, 0, 1, 0, 1, 0, 0, 0, 3'b010},
        '{ADDI, 0, 0, 1, 1, 0, 0, 0, 0, 3'b010}, '{ADDI, 0, 0, 1, 9, 0, 0, 0, 0, 3'b010},
        '{ADDI, 0, 0, 1, 10, 0, 0, 1, 0, 3'b000},
        '{JMP, 0, 0, 1, 0, 1, 0, 0, 0, 3'b010}, '{JMP, 0, 0, 1, 1, 0, 0, 0, 0, 3'b010},
        '{JMP, 0, 0, 1, 11, 1, 0, 0, 0, 3'b000},
        '{LW, 0, 0, 1, 0, 1, 0, 0, 0, 3'b010}, '{LW, 0, 0, 1, 1, 0, 0, 0, 0, 3'b010},
        '{LW, 0, 0, 1, 2, 0, 0, 0, 0, 3'b010}, '{LW, 0, 0, 0, 3, 0, 0, 0, 0, 3'b000},
        '{LW, 0, 0, 0, 3, 0, 0, 0, 0, 3'b000}, '{LW, 0, 0, 1, 3, 0, 0, 0, 0, 3'b000},
        '{LW, 0, 0, 1, 4, 0, 0, 1, 0, 3'b000},
        '{LW, 0, 0, 1, 0, 1, 0, 0, 0, 3'b010}, '{LW, 0, 0, 1, 1, 0, 0, 0, 0, 3'b010},
        '{LW, 0, 0, 0, 2, 0, 0, 0, 0, 3'b010}
    };

    logic [5:0] ops [7] = '{LW, SW, RT, BEQ, ADDI, JMP, BAD};
    logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("reset_state", 32'(state_o), 0);
            check("reset_strobes", 32'({pcen, irwrite, memwrite, regwrite}), 0);
        end
        for (int i = 0; i < NR; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            op = rows[i].op;
            funct = rows[i].funct;
            zero = rows[i].z;
            mem_ready = rows[i].r;
            @(negedge clk);
            #1;
            check("state", 32'(state_o), 32'(rows[i].st));
            check("pcen", 32'(pcen), 32'(rows[i].pc));
            check("memwrite", 32'(memwrite), 32'(rows[i].mw));
            check("regwrite", 32'(regwrite), 32'(rows[i].rw));
            check("illegal_op", 32'(illegal_op), 32'(rows[i].ill));
            check("alucontrol", 32'(alucontrol), 32'(rows[i].aluc));
            if (i == 0) check("first_fetch_alusrcb", 32'(alusrcb), 1);
            if (i == 4) check("lw_memtoreg", 32'(memtoreg), 1);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("memrd_stall_state", 32'(state_o), 3);
        check("memrd_stall_iord", 32'(iord), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_stall_reset_state", 32'(state_o), 0);
        check("mid_stall_reset_iord", 32'(iord), 0);
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (!reset) reset = ($urandom_range(0, 2) == 0);
            else reset = ($urandom_range(0, 299) != 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            zero = 1'($urandom_range(0, 1));
            if (cur() == 0) begin
                op = ops[$urandom_range(0, 6)];
                if (op == BAD) op = 6'($urandom);
                funct = fns[$urandom_range(0, 5)];
                if (funct == 6'b000111) funct = 6'($urandom);
            end
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Sequencing controller for the multicycle MIPS datapath: one shared ALU, unified instruction/data memory, instruction register.
- Moore FSM walks each instruction through fetch, decode, execute, memory and writeback. It drives all datapath selects and write strobes.
- Memory accesses stall on a mem_ready handshake. The existing ALU-decode encoding is kept.

Parameters:
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0] from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pcen  out  1  PC register enable = pcwrite | (branch & zero).
- irwrite  out  1  instruction register load.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = Data register.
- regdst  out  1  destination register: 0 = rt, 1 = rd.
- alusrca  out  1  ALU A: 0 = PC, 1 = reg A.
- alusrcb  out  2  ALU B: 00 = reg B, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alucontrol  out  3  ALU operation.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 are unreachable and recover to FETCH next cycle with all outputs 0.
- Reset: while reset=0, state=FETCH and every output is forced to 0, including pcen, irwrite, memwrite and regwrite. The first FETCH action happens on the first rising edge after reset rises.
- Default value of every output is 0 unless listed for the state below.
- aluop per state: 00 = add, 01 = sub, 10 = funct-decoded.
- alucontrol mapping:
  - aluop 00 → 010; aluop 01 → 110.
  - aluop 10 by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, any other funct → 010.
- FETCH: iord=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and pcwrite=1 only when mem_ready=1, then go to DECODE. Otherwise hold FETCH with no strobes.
- DECODE: alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - any other → FETCH, with illegal_op=1 for this cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. op=100011 → MEMRD, else → MEMWR.
- MEMRD: iord=1. Hold until mem_ready=1, then → MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1 every cycle held. Exit to FETCH in the cycle mem_ready=1.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 → RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1 → FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, so pcen=zero → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWB.
- ADDIWB: regdst=0, regwrite=1 → FETCH.
- JEX: pcsrc=10, pcwrite=1 → FETCH.
- Cycle counts with no stalls: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3. Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Stall and reset interaction: mem_ready is sampled only in FETCH, MEMRD and MEMWR. A reset asserted mid-stall returns immediately to FETCH with strobes cleared.
- zero is used only in BEQEX; it is ignored in every other state.

Test Plan:
- Reset and first fetch: reset=0 for 3 cycles with mem_ready=1 → all outputs 0, state_o=0. After release, the first cycle has irwrite=1, pcen=1, alusrcb=01.
- lw, op=100011, mem_ready=1 → state_o sequence 0,1,2,3,4,0. The MEMWB cycle has regwrite=1, memtoreg=1.
- sw with mem_ready low for 2 MEMWR cycles → memwrite=1 for 3 consecutive cycles, then FETCH. regwrite stays 0 throughout.
- R-type sub, op=000000, funct=100010 → alucontrol=110 in RTYPEEX. RTYPEWB has regdst=1, regwrite=1.
- beq, op=000100: zero=1 → pcen=1 with pcsrc=01 in BEQEX. Repeat with zero=0 → pcen=0, and the next state is FETCH in both cases.
- Illegal op=111111 → illegal_op=1 for exactly 1 cycle in DECODE, then FETCH. No regwrite or memwrite is ever asserted.
